rv32i_fetch_ctrl: RTL

- Sequences the synchronous-read instruction memory: generates the fetch address each cycle and tracks the one-cycle read latency.
- Absorbs back-pressure from IF/ID with a one-entry skid buffer and squashes in-flight reads on branch/jump redirect.
- Sits between the PC logic/EX redirect path and the instruction memory; delivers a {valid, pc, inst} packet to the IF/ID register.

---
 rtl/rv32i_fetch_pkg.sv | 13 +
 rtl/rv32i_fetch_skid.sv | 40 ++++
 rtl/rv32i_fetch_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rv32i_fetch_pkg.sv
// Shared types and constants for the RV32I fetch controller.
// Optional misaligned-redirect trap is enabled by RV32I_FETCH_MISALIGN_CHK_EN.
package rv32i_fetch_pkg;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HOLD = 1'b1
  } fetch_state_e;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/rv32i_fetch_skid.sv
// One-entry {pc, inst} skid register: capture loads and marks full, release empties.
module rv32i_fetch_skid
  import rv32i_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_capture,
  input  logic             i_release,
  input  logic [WIDTH-1:0] i_pc,
  input  logic [WIDTH-1:0] i_inst,
  output logic             o_full,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_inst
);

  logic             r_full;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_inst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_pc   <= '0;
      r_inst <= '0;
    end else if (i_capture) begin
      r_full <= 1'b1;
      r_pc   <= i_pc;
      r_inst <= i_inst;
    end else if (i_release) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_pc   = r_pc;
  assign o_inst = r_inst;

endmodule

// File: rtl/rv32i_fetch_ctrl.sv
// Instruction fetch sequencer for a 1-cycle synchronous IMEM with a skid buffer and redirect squash.
// Define RV32I_FETCH_MISALIGN_CHK_EN to add o_misalign and park fetch on misaligned redirect targets.
module rv32i_fetch_ctrl
  import rv32i_fetch_pkg::*;
#(
  parameter int unsigned                INST_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0]      RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_stall,
  input  logic                  i_redirect,
  input  logic [INST_WIDTH-1:0] i_redirect_pc,
  output logic [INST_WIDTH-1:0] o_imem_addr,
  input  logic [INST_WIDTH-1:0] i_imem_inst,
`ifdef RV32I_FETCH_MISALIGN_CHK_EN
  output logic                  o_misalign,
`endif
  output logic                  o_valid,
  output logic [INST_WIDTH-1:0] o_pc,
  output logic [INST_WIDTH-1:0] o_inst
);

  fetch_state_e          r_state;
  logic [INST_WIDTH-1:0] r_pc_q;
  logic                  r_req_v;
  logic [INST_WIDTH-1:0] r_req_pc;
  logic                  r_post_rst;

  logic                  w_in_hold;
  logic                  w_capture;
  logic                  w_release;
  logic                  w_valid;
  logic                  w_zero_out;
  logic [INST_WIDTH-1:0] w_redir_pc;
  logic [INST_WIDTH-1:0] w_pkt_inst;
  logic                  w_hold_full;
  logic [INST_WIDTH-1:0] w_hold_pc;
  logic [INST_WIDTH-1:0] w_hold_inst;

`ifdef RV32I_FETCH_MISALIGN_CHK_EN
  logic r_req_mis;
  logic r_hold_mis;
  logic r_park;

  assign w_redir_pc = i_redirect_pc;
  assign w_pkt_inst = r_req_mis ? INST_WIDTH'(RV32I_NOP) : i_imem_inst;
`else
  assign w_redir_pc = i_redirect_pc & ~INST_WIDTH'(3);
  assign w_pkt_inst = i_imem_inst;
`endif

  assign w_in_hold  = (r_state == FETCH_HOLD);
  assign w_capture  = ~rst & ~i_redirect & i_stall & ~w_in_hold & r_req_v;
  assign w_release  = ~rst & w_in_hold & (i_redirect | ~i_stall);
  assign w_zero_out = rst | r_post_rst;

  rv32i_fetch_skid #(
    .WIDTH (INST_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_capture (w_capture),
    .i_release (w_release),
    .i_pc      (r_req_pc),
    .i_inst    (w_pkt_inst),
    .o_full    (w_hold_full),
    .o_pc      (w_hold_pc),
    .o_inst    (w_hold_inst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH_RUN;
      r_pc_q     <= RESET_PC;
      r_req_v    <= 1'b0;
      r_req_pc   <= '0;
      r_post_rst <= 1'b1;
`ifdef RV32I_FETCH_MISALIGN_CHK_EN
      r_req_mis  <= 1'b0;
      r_hold_mis <= 1'b0;
      r_park     <= 1'b0;
`endif
    end else begin
      r_post_rst <= 1'b0;
      if (i_redirect) begin
        r_pc_q  <= w_redir_pc;
        r_req_v <= 1'b0;
        r_state <= FETCH_RUN;
`ifdef RV32I_FETCH_MISALIGN_CHK_EN
        r_req_mis <= 1'b0;
        r_park    <= 1'b0;
`endif
      end else if (i_stall) begin
        // pc_q is not advanced, so IMEM keeps re-reading the word that follows the held packet
        if (w_capture) begin
          r_state <= FETCH_HOLD;
`ifdef RV32I_FETCH_MISALIGN_CHK_EN
          r_hold_mis <= r_req_mis;
`endif
        end
      end else begin
        r_state <= FETCH_RUN;
`ifdef RV32I_FETCH_MISALIGN_CHK_EN
        if (r_park) begin
          r_req_v   <= 1'b0;
          r_req_mis <= 1'b0;
        end else if (r_pc_q[1:0] != 2'b00) begin
          // emit a single NOP trap packet for the bad target, then park until redirected
          r_req_pc  <= r_pc_q;
          r_req_v   <= 1'b1;
          r_req_mis <= 1'b1;
          r_park    <= 1'b1;
        end else begin
          r_req_pc  <= r_pc_q;
          r_req_v   <= 1'b1;
          r_req_mis <= 1'b0;
          r_pc_q    <= r_pc_q + INST_WIDTH'(PC_STEP);
        end
`else
        r_req_pc <= r_pc_q;
        r_req_v  <= 1'b1;
        r_pc_q   <= r_pc_q + INST_WIDTH'(PC_STEP);
`endif
      end
    end
  end

  always_comb begin
    w_valid = 1'b0;
    o_pc    = '0;
    o_inst  = '0;
    if (!rst) begin
      w_valid = ~i_redirect & (w_in_hold ? w_hold_full : r_req_v);
    end
    if (!w_zero_out) begin
      o_pc   = w_in_hold ? w_hold_pc   : r_req_pc;
      o_inst = w_in_hold ? w_hold_inst : w_pkt_inst;
    end
  end

  assign o_valid     = w_valid;
  assign o_imem_addr = r_pc_q;

`ifdef RV32I_FETCH_MISALIGN_CHK_EN
  assign o_misalign = w_valid & (w_in_hold ? r_hold_mis : r_req_mis);
`endif

endmodule
